// File: rtl/sonos_pkg.sv
// Shared op encodings, FSM state type and counter width for the SONOS pulse sequencer.
package sonos_pkg;

    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_PROGRAM = 2'b01;
    localparam logic [1:0] OP_ERASE   = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StRecover,
        StDone
    } state_e;

endpackage

// File: rtl/sonos_sync2.sv
// Two-flop synchronizer for the asynchronous sense comparator output.
module sonos_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d};
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/sonos_pulse_sequencer.sv
// Timed SETUP/PULSE/RECOVER sequencer driving the SONOS cell array drivers.
// Define SONOS_PROGRAM_VERIFY_EN to add read-back verify with retries after PROGRAM.
module sonos_pulse_sequencer
    import sonos_pkg::*;
#(
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned PGM_CYCLES    = 200,
    parameter int unsigned ERS_CYCLES    = 1000,
    parameter int unsigned RD_CYCLES     = 8,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              rsp_valid,
    output logic              rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] wl_addr,
    output logic              drv_pgm,
    output logic              drv_ers,
    output logic              drv_rd,
    output logic              sense_strobe,
    input  logic              sense_in
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535) begin : gen_bad_settle
        $error("SETTLE_CYCLES out of range");
    end
    if (PGM_CYCLES < 1 || PGM_CYCLES > 65535) begin : gen_bad_pgm
        $error("PGM_CYCLES out of range");
    end
    if (ERS_CYCLES < 1 || ERS_CYCLES > 65535) begin : gen_bad_ers
        $error("ERS_CYCLES out of range");
    end
    if (RD_CYCLES < 1 || RD_CYCLES > 65535) begin : gen_bad_rd
        $error("RD_CYCLES out of range");
    end
    if (MAX_RETRY > 65535) begin : gen_bad_retry
        $error("MAX_RETRY out of range");
    end

    // Counter loads N-1 on phase entry and the phase ends at zero.
    localparam logic [CNT_W-1:0] SettleLd = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PgmLd    = CNT_W'(PGM_CYCLES - 1);
    localparam logic [CNT_W-1:0] ErsLd    = CNT_W'(ERS_CYCLES - 1);
    localparam logic [CNT_W-1:0] RdLd     = CNT_W'(RD_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               sense_q, sense_d;
    logic               rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               sense_sync;
    logic               cnt_done;
    logic               rd_pulse;
    logic               in_pulse;
    logic [CNT_W-1:0]   pulse_ld;

`ifdef SONOS_PROGRAM_VERIFY_EN
    logic               vfy_q, vfy_d;
    logic [CNT_W-1:0]   retry_q, retry_d;
`endif

    sonos_sync2 u_sense_sync (
        .clk (clk),
        .rst (rst),
        .d   (sense_in),
        .q   (sense_sync)
    );

    assign cnt_done = (cnt_q == '0);
    assign in_pulse = (state_q == StPulse);

`ifdef SONOS_PROGRAM_VERIFY_EN
    assign rd_pulse = (op_q == OP_READ) || vfy_q;
`else
    assign rd_pulse = (op_q == OP_READ);
`endif

    always_comb begin
        pulse_ld = ErsLd;
        if (rd_pulse) begin
            pulse_ld = RdLd;
        end else if (op_q == OP_PROGRAM) begin
            pulse_ld = PgmLd;
        end
    end

    assign cmd_ready    = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign rsp_valid    = (state_q == StDone);
    assign drv_rd       = in_pulse && rd_pulse;
    assign drv_pgm      = in_pulse && !rd_pulse && (op_q == OP_PROGRAM);
    assign drv_ers      = in_pulse && (op_q == OP_ERASE);
    assign sense_strobe = drv_rd && cnt_done;
    assign wl_addr      = addr_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        sense_d    = sense_strobe ? sense_sync : sense_q;
`ifdef SONOS_PROGRAM_VERIFY_EN
        vfy_d      = vfy_q;
        retry_d    = retry_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    addr_d = cmd_addr;
`ifdef SONOS_PROGRAM_VERIFY_EN
                    vfy_d   = 1'b0;
                    retry_d = '0;
`endif
                    if (cmd_op == OP_ILLEGAL) begin
                        state_d    = StDone;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = 1'b0;
                    end else begin
                        state_d = StSetup;
                        cnt_d   = SettleLd;
                    end
                end
            end
            StSetup: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_done) begin
                    state_d = StPulse;
                    cnt_d   = pulse_ld;
                end
            end
            StPulse: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_done) begin
                    state_d = StRecover;
                    cnt_d   = SettleLd;
                end
            end
            StRecover: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_done) begin
                    state_d    = StDone;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = (op_q == OP_READ) ? sense_q : 1'b0;
`ifdef SONOS_PROGRAM_VERIFY_EN
                    if (op_q == OP_PROGRAM && !vfy_q) begin
                        // Program pulse finished: run a read-back at the same address.
                        state_d = StSetup;
                        cnt_d   = SettleLd;
                        vfy_d   = 1'b1;
                    end else if (op_q == OP_PROGRAM && sense_q) begin
                        if (retry_q < CNT_W'(MAX_RETRY)) begin
                            state_d = StSetup;
                            cnt_d   = SettleLd;
                            vfy_d   = 1'b0;
                            retry_d = retry_q + 1'b1;
                        end else begin
                            rsp_err_d  = 1'b1;
                            rsp_data_d = 1'b1;
                        end
                    end
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= OP_READ;
            addr_q     <= '0;
            sense_q    <= 1'b0;
            rsp_data_q <= 1'b0;
            rsp_err_q  <= 1'b0;
`ifdef SONOS_PROGRAM_VERIFY_EN
            vfy_q      <= 1'b0;
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            sense_q    <= sense_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
`ifdef SONOS_PROGRAM_VERIFY_EN
            vfy_q      <= vfy_d;
            retry_q    <= retry_d;
`endif
        end
    end

endmodule

// File: tb/tb_sonos_pulse_sequencer.sv
// Scoreboard bench for sonos_pulse_sequencer with SETTLE=2, RD=3, PGM=5, ERS=7.
module tb_sonos_pulse_sequencer;

    localparam int S  = 2;
    localparam int R  = 3;
    localparam int P  = 5;
    localparam int E  = 7;
    localparam int MR = 3;
    localparam int T  = 4 * S + P + R;

    localparam logic [1:0] RD  = 2'b00;
    localparam logic [1:0] PG  = 2'b01;
    localparam logic [1:0] ER  = 2'b10;
    localparam logic [1:0] ILL = 2'b11;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_addr;
    logic       rsp_valid;
    logic       rsp_data;
    logic       rsp_err;
    logic       busy;
    logic [3:0] wl_addr;
    logic       drv_pgm;
    logic       drv_ers;
    logic       drv_rd;
    logic       sense_strobe;
    logic       sense_in;

    int checks = 0;
    int errors = 0;
    logic [1:0] rsp_q[$];
    logic last_data = 1'b0;
    logic last_err  = 1'b0;

    sonos_pulse_sequencer #(
        .ADDR_W        (4),
        .SETTLE_CYCLES (S),
        .PGM_CYCLES    (P),
        .ERS_CYCLES    (E),
        .RD_CYCLES     (R),
        .MAX_RETRY     (MR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .wl_addr      (wl_addr),
        .drv_pgm      (drv_pgm),
        .drv_ers      (drv_ers),
        .drv_rd       (drv_rd),
        .sense_strobe (sense_strobe),
        .sense_in     (sense_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int attempts(logic sense);
`ifdef SONOS_PROGRAM_VERIFY_EN
        return sense ? MR + 1 : 1;
`else
        return 1;
`endif
    endfunction

    function automatic int exp_lat(logic [1:0] op, logic sense);
        case (op)
            RD:      return 2 * S + R + 1;
            ER:      return 2 * S + E + 1;
`ifdef SONOS_PROGRAM_VERIFY_EN
            PG:      return attempts(sense) * T + 1;
`else
            PG:      return 2 * S + P + 1;
`endif
            default: return 1;
        endcase
    endfunction

    // {data, err}
    function automatic logic [1:0] exp_rsp(logic [1:0] op, logic sense);
        if (op == ILL) return 2'b01;
        if (op == RD) return {sense, 1'b0};
`ifdef SONOS_PROGRAM_VERIFY_EN
        if (op == PG && sense) return 2'b11;
`endif
        return 2'b00;
    endfunction

    // {pgm, ers, rd} expected in cycle k after accept
    function automatic logic [2:0] exp_drv(logic [1:0] op, int k, logic sense);
        int off;
        exp_drv = 3'b000;
        case (op)
            RD: if (k > S && k <= S + R) exp_drv = 3'b001;
            ER: if (k > S && k <= S + E) exp_drv = 3'b010;
            PG: begin
`ifdef SONOS_PROGRAM_VERIFY_EN
                if (k >= 1 && (k - 1) / T < attempts(sense)) begin
                    off = (k - 1) % T + 1;
                    if (off > S && off <= S + P) exp_drv = 3'b100;
                    else if (off > 3 * S + P && off <= 3 * S + P + R) exp_drv = 3'b001;
                end
`else
                off = k;
                if (off > S && off <= S + P) exp_drv = 3'b100;
`endif
            end
            default: exp_drv = 3'b000;
        endcase
    endfunction

    task automatic accept(logic [1:0] op, logic [3:0] addr, logic sense);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        sense_in  = sense;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready op=%b got %b expected 1", op, cmd_ready);
        end
        rsp_q.push_back(exp_rsp(op, sense));
    endtask

    task automatic follow(logic [1:0] op, logic [3:0] addr, logic sense,
                          bit hold, logic [1:0] nop, logic [3:0] naddr);
        int lat;
        bit seen;
        logic [2:0] e;
        logic [2:0] nx;
        logic [1:0] exp;
        lat  = exp_lat(op, sense);
        seen = 1'b0;
        for (int k = 1; k <= lat + 4 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) begin
                    cmd_op   = nop;
                    cmd_addr = naddr;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            e  = exp_drv(op, k, sense);
            nx = exp_drv(op, k + 1, sense);
            checks++;
            if ({drv_pgm, drv_ers, drv_rd} !== e) begin
                errors++;
                $display("FAIL drivers op=%b k=%0d got %b expected %b", op, k,
                         {drv_pgm, drv_ers, drv_rd}, e);
            end
            checks++;
            if (sense_strobe !== (e[0] & ~nx[0])) begin
                errors++;
                $display("FAIL strobe op=%b k=%0d got %b expected %b", op, k, sense_strobe,
                         e[0] & ~nx[0]);
            end
            checks++;
            if (wl_addr !== addr) begin
                errors++;
                $display("FAIL wl_addr k=%0d got %0d expected %0d", k, wl_addr, addr);
            end
            checks++;
            if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy k=%0d got busy=%b ready=%b expected 1/0", k, busy, cmd_ready);
            end
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (k != lat) begin
                    errors++;
                    $display("FAIL latency op=%b got %0d expected %0d", op, k, lat);
                end
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty op=%b got response expected none", op);
                end else begin
                    exp = rsp_q.pop_front();
                    checks++;
                    if ({rsp_data, rsp_err} !== exp) begin
                        errors++;
                        $display("FAIL response op=%b got data/err=%b expected %b", op,
                                 {rsp_data, rsp_err}, exp);
                    end
                    last_data = exp[1];
                    last_err  = exp[0];
                end
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL timeout op=%b got no rsp_valid expected at cycle %0d", op, lat);
            if (rsp_q.size() != 0) void'(rsp_q.pop_front());
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || {drv_pgm, drv_ers, drv_rd} !== 3'b000) begin
            errors++;
            $display("FAIL post_idle op=%b got ready=%b valid=%b drv=%b expected 1/0/000", op,
                     cmd_ready, rsp_valid, {drv_pgm, drv_ers, drv_rd});
        end
        checks++;
        if ({rsp_data, rsp_err} !== {last_data, last_err}) begin
            errors++;
            $display("FAIL rsp_hold op=%b got %b expected %b", op, {rsp_data, rsp_err},
                     {last_data, last_err});
        end
    endtask

    task automatic run_cmd(logic [1:0] op, logic [3:0] addr, logic sense);
        accept(op, addr, sense);
        follow(op, addr, sense, 1'b0, 2'b00, 4'd0);
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 4'd0;
        sense_in  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got ready=%b busy=%b valid=%b expected 1/0/0", cmd_ready,
                     busy, rsp_valid);
        end
        checks++;
        if ({drv_pgm, drv_ers, drv_rd, sense_strobe} !== 4'b0000 || wl_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset_drv got drv=%b strobe=%b addr=%0d expected 000/0/0",
                     {drv_pgm, drv_ers, drv_rd}, sense_strobe, wl_addr);
        end
        checks++;
        if ({rsp_data, rsp_err} !== 2'b00) begin
            errors++;
            $display("FAIL reset_rsp got %b expected 00", {rsp_data, rsp_err});
        end
    endtask

    task automatic test_read;
        run_cmd(RD, 4'd5, 1'b1);
        run_cmd(RD, 4'd12, 1'b0);
    endtask

    task automatic test_program;
        run_cmd(PG, 4'd9, 1'b0);
    endtask

    task automatic test_erase_illegal;
        run_cmd(ER, 4'd0, 1'b0);
        run_cmd(ILL, 4'd6, 1'b0);
        run_cmd(RD, 4'd3, 1'b1);
    endtask

    task automatic test_reset_mid;
        bit spurious;
        cmd_valid = 1'b1;
        cmd_op    = PG;
        cmd_addr  = 4'd9;
        sense_in  = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (drv_pgm !== 1'b1) begin
            errors++;
            $display("FAIL mid_pulse got drv_pgm=%b expected 1", drv_pgm);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({drv_pgm, drv_ers, drv_rd} !== 3'b000 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got drv=%b valid=%b expected 000/0",
                     {drv_pgm, drv_ers, drv_rd}, rsp_valid);
        end
        rst       = 1'b0;
        last_data = 1'b0;
        last_err  = 1'b0;
        spurious  = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || {drv_pgm, drv_ers, drv_rd} !== 3'b000) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL reset_discard got activity after reset expected none");
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_back_to_back;
        accept(RD, 4'd5, 1'b1);
        follow(RD, 4'd5, 1'b1, 1'b1, PG, 4'd9);
        accept(PG, 4'd9, 1'b1);
        follow(PG, 4'd9, 1'b1, 1'b0, 2'b00, 4'd0);
    endtask

`ifdef SONOS_PROGRAM_VERIFY_EN
    task automatic test_verify;
        run_cmd(PG, 4'd7, 1'b1);
        run_cmd(PG, 4'd2, 1'b0);
    endtask
`endif

    initial begin
        rst = 1'b1;
        test_reset();
        test_read();
        test_program();
        test_erase_illegal();
        test_reset_mid();
        test_back_to_back();
`ifdef SONOS_PROGRAM_VERIFY_EN
        test_verify();
`endif
        checks++;
        if (rsp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d entries expected 0", rsp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sonos_pulse_sequencer.md
Name: sonos_pulse_sequencer

Overview:
- Digital controller that drives the SONOS flash cell array of the flash-party analog tile.
- Accepts READ, PROGRAM and ERASE commands over a valid/ready interface.
- Generates timed word-line address and driver enables (program, erase, read) for the analog macro.
- Samples the macro's sense comparator and returns a one-cycle response.
- Sits between the tile's digital command decoder (ui_in/uio pins) and the analog pad drivers.

Parameters:
- ADDR_W, 4, word-line/cell address width.
- SETTLE_CYCLES, 4, address-settle and recovery gap around every pulse (1..65535).
- PGM_CYCLES, 200, program pulse width in clk cycles (1..65535).
- ERS_CYCLES, 1000, erase pulse width (1..65535).
- RD_CYCLES, 8, read-bias width before sense (1..65535).
- MAX_RETRY, 3, program-verify retries; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00=READ, 01=PROGRAM, 10=ERASE, 11=illegal
- cmd_addr  in  ADDR_W  target cell
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  1  sensed bit (1=erased, 0=programmed)
- rsp_err  out  1  illegal op or verify failure
- busy  out  1  state != IDLE
- wl_addr  out  ADDR_W  latched address to the analog macro
- drv_pgm  out  1  program driver enable
- drv_ers  out  1  erase driver enable
- drv_rd  out  1  read-bias enable
- sense_strobe  out  1  high on the last RD cycle
- sense_in  in  1  asynchronous comparator output

Behaviour:
- Reset values: cmd_ready=1 after reset release; every other output 0; wl_addr=0; state IDLE.
- Reset mid-operation: all driver enables are 0 from the next edge. No response is emitted and any in-flight command is discarded.
- Accept: cmd_valid && cmd_ready at edge 0. cmd_addr is latched into wl_addr; op is latched.
- States: IDLE -> SETUP (SETTLE_CYCLES) -> PULSE (PGM/ERS/RD_CYCLES) -> RECOVER (SETTLE_CYCLES) -> DONE (1 cycle) -> IDLE.
- Latency: rsp_valid is high in cycle 2*SETTLE+PULSE+1 after accept. cmd_ready returns the following cycle.
- During PULSE exactly one of drv_pgm/drv_ers/drv_rd is high, matching the op. At most one driver is ever high; drivers are 0 in SETUP, RECOVER, DONE and IDLE.
- READ: on the last PULSE cycle sense_strobe=1 and the synchronized sense_in is captured into rsp_data.
- PROGRAM/ERASE: rsp_data=0 and rsp_err=0.
- Illegal op (11): IDLE -> DONE next cycle. No drivers, rsp_err=1, rsp_data=0. rsp_valid is at cycle 1 after accept.
- sense_in passes through a 2-flop synchronizer before use.
- Phase counter is 16 bits and loads N-1 on phase entry; the phase ends when the counter hits 0.
- rsp_data/rsp_err hold their value until the next rsp_valid.
- cmd_valid while busy is ignored (cmd_ready=0).

Optional Feature:
- Macro: SONOS_PROGRAM_VERIFY_EN.
- Defined: after the PROGRAM RECOVER phase the block enters VERIFY, a full READ sequence (SETUP, RD PULSE, RECOVER) at the same address.
  - Sensed 0: DONE with rsp_err=0, rsp_data=0.
  - Sensed 1: re-issue the program pulse, up to MAX_RETRY extra attempts. After exhaustion, DONE with rsp_err=1, rsp_data=1.
  - Retry counter clears on accept.
- Undefined: no VERIFY state, MAX_RETRY unused, PROGRAM behaves as in Behaviour.

Decomposition:
- sonos_pkg: op encodings (OP_READ, OP_PROGRAM, OP_ERASE), state enum, counter width constant CNT_W=16.
- Sub-module sonos_sync2: 2-flop synchronizer for sense_in, reset to 0.

Test Plan (SETTLE=2, RD=3, PGM=5, ERS=7, ADDR_W=4):
- READ addr=5, sense_in=1 -> wl_addr=5 from cycle 1; drv_rd high cycles 3-5; sense_strobe at cycle 5; rsp_valid at cycle 8 with rsp_data=1, rsp_err=0; cmd_ready high at cycle 9.
- PROGRAM addr=9 -> drv_pgm high exactly cycles 3-7, other drivers 0; rsp_valid at cycle 10, rsp_err=0.
- ERASE addr=0, then cmd_op=11 -> drv_ers high cycles 3-9, rsp_valid at 12. The illegal op gets rsp_valid 1 cycle after its accept with rsp_err=1 and no drivers.
- Reset asserted during a PROGRAM pulse (cycle 5) -> all drivers 0 at the next edge, no rsp_valid, cmd_ready=1 after release.
- cmd_valid held high during a READ -> second command accepted only at the first cmd_ready cycle (cycle 9); no overlap of drivers.
- With SONOS_PROGRAM_VERIFY_EN and sense_in stuck at 1 -> 4 program pulses, each followed by a read; rsp_err=1, rsp_data=1. With sense_in=0 -> one pulse, rsp_err=0.
